// File: rtl/fc_match_stage.sv
// Firing-control matching stage: pairs left/right operand tokens sharing a {node, gen}
// key through a DEPTH-entry associative store; unary tokens bypass the store.
module fc_match_stage #(
  parameter  int unsigned NODE_W = 16,
  parameter  int unsigned GEN_W  = 12,
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld_i,
  output logic              in_rdy_o,
  input  logic              in_lr_i,
  input  logic [NODE_W-1:0] in_node_i,
  input  logic [GEN_W-1:0]  in_gen_i,
  input  logic [DATA_W-1:0] in_opr_i,
  input  logic              in_uni_i,
  input  logic              flush_i,
  output logic              out_vld_o,
  input  logic              out_rdy_i,
  output logic [NODE_W-1:0] out_node_o,
  output logic [GEN_W-1:0]  out_gen_o,
  output logic [DATA_W-1:0] out_l_o,
  output logic [DATA_W-1:0] out_r_o,
  output logic              out_uni_o,
  output logic [CW-1:0]     cnt_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              stall_full_o
);

  localparam int unsigned KEY_W = NODE_W + GEN_W;
  localparam int unsigned IW    = $clog2(DEPTH);

  // S0 stage
  logic              s0_vld_q, s0_vld_d;
  logic              s0_lr_q,  s0_lr_d;
  logic              s0_uni_q, s0_uni_d;
  logic [KEY_W-1:0]  s0_key_q, s0_key_d;
  logic [DATA_W-1:0] s0_opr_q, s0_opr_d;

  // Matching store
  logic [DEPTH-1:0]  ent_vld_q, ent_vld_d;
  logic [KEY_W-1:0]  ent_key_q [DEPTH];
  logic [KEY_W-1:0]  ent_key_d [DEPTH];
  logic [DATA_W-1:0] ent_dat_q [DEPTH];
  logic [DATA_W-1:0] ent_dat_d [DEPTH];
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              stall_q, stall_d;

  // S1 output register
  logic              out_vld_q, out_vld_d;
  logic [KEY_W-1:0]  out_key_q, out_key_d;
  logic [DATA_W-1:0] out_l_q,   out_l_d;
  logic [DATA_W-1:0] out_r_q,   out_r_d;
  logic              out_uni_q, out_uni_d;

  logic          hit, free_vld;
  logic [IW-1:0] hit_idx, free_idx;
  logic          full, fire, s0_adv, accept;

  // Priority lookup: lowest-index key hit and lowest-index free slot
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_vld = 1'b0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && ent_vld_q[i] && (ent_key_q[i] == s0_key_q)) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (!free_vld && !ent_vld_q[i]) begin
        free_vld = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  assign full     = (cnt_q == CW'(DEPTH));
  assign fire     = s0_vld_q & (s0_uni_q | hit);
  assign s0_adv   = ~flush_i & (fire ? (~out_vld_q | out_rdy_i) : (s0_vld_q & ~full));
  assign in_rdy_o = ~flush_i & (~s0_vld_q | s0_adv);
  assign accept   = in_vld_i & in_rdy_o;

  always_comb begin
    s0_vld_d  = s0_vld_q;
    s0_lr_d   = s0_lr_q;
    s0_uni_d  = s0_uni_q;
    s0_key_d  = s0_key_q;
    s0_opr_d  = s0_opr_q;
    ent_vld_d = ent_vld_q;
    ent_key_d = ent_key_q;
    ent_dat_d = ent_dat_q;
    cnt_d     = cnt_q;
    stall_d   = stall_q | (s0_vld_q & ~s0_uni_q & ~hit & full);
    out_vld_d = out_vld_q;
    out_key_d = out_key_q;
    out_l_d   = out_l_q;
    out_r_d   = out_r_q;
    out_uni_d = out_uni_q;

    if (flush_i) begin
      ent_vld_d = '0;
      s0_vld_d  = 1'b0;
      cnt_d     = '0;
    end else begin
      if (s0_adv && !s0_uni_q) begin
        if (hit) begin
          ent_vld_d[hit_idx] = 1'b0;
          cnt_d              = cnt_q - CW'(1);
        end else begin
          ent_vld_d[free_idx] = 1'b1;
          ent_key_d[free_idx] = s0_key_q;
          ent_dat_d[free_idx] = s0_opr_q;
          cnt_d               = cnt_q + CW'(1);
        end
      end
      if (accept) begin
        s0_vld_d = 1'b1;
        s0_lr_d  = in_lr_i;
        s0_uni_d = in_uni_i;
        s0_key_d = {in_node_i, in_gen_i};
        s0_opr_d = in_opr_i;
      end else if (s0_adv) begin
        s0_vld_d = 1'b0;
      end
    end

    // S1 loads on a firing advance, otherwise drains on out_rdy_i
    if (s0_adv && fire) begin
      out_vld_d = 1'b1;
      out_key_d = s0_key_q;
      out_uni_d = s0_uni_q;
      out_l_d   = s0_opr_q;
      out_r_d   = '0;
      if (!s0_uni_q) begin
        if (s0_lr_q) begin
          out_l_d = ent_dat_q[hit_idx];
          out_r_d = s0_opr_q;
        end else begin
          out_r_d = ent_dat_q[hit_idx];
        end
      end
    end else if (out_rdy_i) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_vld_q  <= 1'b0;
      s0_lr_q   <= 1'b0;
      s0_uni_q  <= 1'b0;
      s0_key_q  <= '0;
      s0_opr_q  <= '0;
      ent_vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_key_q[i] <= '0;
        ent_dat_q[i] <= '0;
      end
      cnt_q     <= '0;
      stall_q   <= 1'b0;
      out_vld_q <= 1'b0;
      out_key_q <= '0;
      out_l_q   <= '0;
      out_r_q   <= '0;
      out_uni_q <= 1'b0;
    end else begin
      s0_vld_q  <= s0_vld_d;
      s0_lr_q   <= s0_lr_d;
      s0_uni_q  <= s0_uni_d;
      s0_key_q  <= s0_key_d;
      s0_opr_q  <= s0_opr_d;
      ent_vld_q <= ent_vld_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_key_q[i] <= ent_key_d[i];
        ent_dat_q[i] <= ent_dat_d[i];
      end
      cnt_q     <= cnt_d;
      stall_q   <= stall_d;
      out_vld_q <= out_vld_d;
      out_key_q <= out_key_d;
      out_l_q   <= out_l_d;
      out_r_q   <= out_r_d;
      out_uni_q <= out_uni_d;
    end
  end

  assign out_vld_o    = out_vld_q;
  assign out_node_o   = out_key_q[KEY_W-1:GEN_W];
  assign out_gen_o    = out_key_q[GEN_W-1:0];
  assign out_l_o      = out_l_q;
  assign out_r_o      = out_r_q;
  assign out_uni_o    = out_uni_q;
  assign cnt_o        = cnt_q;
  assign full_o       = full;
  assign empty_o      = (cnt_q == '0);
  assign stall_full_o = stall_q;

endmodule

// File: tb/tb_fc_match_stage.sv
// Self-checking bench for fc_match_stage: directed vector table, corner sequences,
// and randomized traffic against a transaction-level matching model.
module tb_fc_match_stage;

  localparam int unsigned NODE_W = 16;
  localparam int unsigned GEN_W  = 12;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CW     = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_vld_i, in_rdy_o, in_lr_i, in_uni_i, flush_i;
  logic [NODE_W-1:0] in_node_i;
  logic [GEN_W-1:0]  in_gen_i;
  logic [DATA_W-1:0] in_opr_i;
  logic              out_vld_o, out_rdy_i, out_uni_o;
  logic [NODE_W-1:0] out_node_o;
  logic [GEN_W-1:0]  out_gen_o;
  logic [DATA_W-1:0] out_l_o, out_r_o;
  logic [CW-1:0]     cnt_o;
  logic              full_o, empty_o, stall_full_o;

  fc_match_stage #(.NODE_W(NODE_W), .GEN_W(GEN_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_vld_i(in_vld_i), .in_rdy_o(in_rdy_o), .in_lr_i(in_lr_i),
    .in_node_i(in_node_i), .in_gen_i(in_gen_i), .in_opr_i(in_opr_i), .in_uni_i(in_uni_i),
    .flush_i(flush_i), .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i),
    .out_node_o(out_node_o), .out_gen_o(out_gen_o), .out_l_o(out_l_o), .out_r_o(out_r_o),
    .out_uni_o(out_uni_o), .cnt_o(cnt_o), .full_o(full_o), .empty_o(empty_o),
    .stall_full_o(stall_full_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] node;
    logic [11:0] gen;
    logic        lr0;
    logic [31:0] d0;
    logic        lr1;
    logic [31:0] d1;
    logic        uni;
    logic [31:0] el;
    logic [31:0] er;
    logic        euni;
  } vec_t;

  typedef struct packed {
    logic [27:0] key;
    logic [31:0] l;
    logic [31:0] r;
    logic        uni;
  } exp_t;

  vec_t        vt[4];
  exp_t        exp_q[$];
  logic [31:0] pend [logic [27:0]];
  logic [31:0] cap_l[$], cap_r[$];
  int          cap_c[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic lr, input logic [15:0] node, input logic [11:0] gen,
                       input logic [31:0] opr, input logic uni);
    in_vld_i  = 1'b1;
    in_lr_i   = lr;
    in_node_i = node;
    in_gen_i  = gen;
    in_opr_i  = opr;
    in_uni_i  = uni;
  endtask

  // Present a token, wait (bounded) for acceptance, return cycles waited
  task automatic send(input logic lr, input logic [15:0] node, input logic [11:0] gen,
                      input logic [31:0] opr, input logic uni, output int waited);
    drive(lr, node, gen, opr, uni);
    waited = 0;
    @(negedge clk);
    while (!in_rdy_o && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_rdy_o) chk("send_accept", 64'(in_rdy_o), 1);
    step();
    in_vld_i = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    @(negedge clk);
    while (!out_vld_o && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    chk("out_vld_seen", 64'(out_vld_o), 1);
  endtask

  // Transaction-level model: a token either fires (unary / partner pending) or waits
  task automatic model_accept();
    logic [27:0] key;
    exp_t        e;
    key   = {in_node_i, in_gen_i};
    e.key = key;
    e.uni = in_uni_i;
    if (in_uni_i) begin
      e.l = in_opr_i;
      e.r = 32'h0;
      exp_q.push_back(e);
    end else if (pend.exists(key)) begin
      e.l = in_lr_i ? pend[key] : in_opr_i;
      e.r = in_lr_i ? in_opr_i : pend[key];
      pend.delete(key);
      exp_q.push_back(e);
    end else begin
      pend[key] = in_opr_i;
    end
  endtask

  task automatic model_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("rnd_spurious", 64'(exp_q.size()), 1);
    end else begin
      e = exp_q.pop_front();
      chk("rnd_key", 64'({out_node_o, out_gen_o}), 64'(e.key));
      chk("rnd_l", 64'(out_l_o), 64'(e.l));
      chk("rnd_r", 64'(out_r_o), 64'(e.r));
      chk("rnd_uni", 64'(out_uni_o), 64'(e.uni));
    end
  endtask

  initial begin
    int w, cyc, nsent, fired;
    logic acc;

    vt[0] = '{16'h0007, 12'h002, 1'b1, 32'h11, 1'b0, 32'h22, 1'b0, 32'h22, 32'h11, 1'b0};
    vt[1] = '{16'h0009, 12'h000, 1'b0, 32'h1234, 1'b0, 32'h0, 1'b1, 32'h1234, 32'h0, 1'b1};
    vt[2] = '{16'hFFFF, 12'hFFF, 1'b0, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0};
    vt[3] = '{16'h0000, 12'h000, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h1, 1'b0, 32'hFFFFFFFF, 32'h1, 1'b0};

    rst = 1'b0; in_vld_i = 1'b0; in_lr_i = 1'b0; in_node_i = '0; in_gen_i = '0;
    in_opr_i = '0; in_uni_i = 1'b0; flush_i = 1'b0; out_rdy_i = 1'b1;
    #12;
    chk("rst_in_rdy", 64'(in_rdy_o), 1);
    chk("rst_out_vld", 64'(out_vld_o), 0);
    chk("rst_out_l", 64'(out_l_o), 0);
    chk("rst_cnt", 64'(cnt_o), 0);
    chk("rst_empty", 64'(empty_o), 1);
    chk("rst_full", 64'(full_o), 0);
    chk("rst_stall", 64'(stall_full_o), 0);
    #11 rst = 1'b1;
    step();

    // Basic left then right pair
    send(1'b0, 16'h0005, 12'h001, 32'hAAAA0000, 1'b0, w);
    step();
    @(negedge clk);
    chk("pair_store_cnt", 64'(cnt_o), 1);
    chk("pair_store_novld", 64'(out_vld_o), 0);
    step();
    send(1'b1, 16'h0005, 12'h001, 32'h0000BBBB, 1'b0, w);
    wait_out(cyc);
    chk("pair_latency", 64'(cyc), 1);
    chk("pair_l", 64'(out_l_o), 64'h AAAA0000);
    chk("pair_r", 64'(out_r_o), 64'h0000BBBB);
    chk("pair_cnt", 64'(cnt_o), 0);
    chk("pair_empty", 64'(empty_o), 1);
    step();

    // Vector table: back-to-back pairs and unary tokens
    for (int v = 0; v < 4; v++) begin
      send(vt[v].lr0, vt[v].node, vt[v].gen, vt[v].d0, vt[v].uni, w);
      if (!vt[v].uni) begin
        send(vt[v].lr1, vt[v].node, vt[v].gen, vt[v].d1, 1'b0, w);
        chk($sformatf("vec%0d_nobubble", v), 64'(w), 0);
      end
      wait_out(cyc);
      chk($sformatf("vec%0d_latency", v), 64'(cyc), 1);
      chk($sformatf("vec%0d_key", v), 64'({out_node_o, out_gen_o}), 64'({vt[v].node, vt[v].gen}));
      chk($sformatf("vec%0d_l", v), 64'(out_l_o), 64'(vt[v].el));
      chk($sformatf("vec%0d_r", v), 64'(out_r_o), 64'(vt[v].er));
      chk($sformatf("vec%0d_uni", v), 64'(out_uni_o), 64'(vt[v].euni));
      chk($sformatf("vec%0d_cnt", v), 64'(cnt_o), 0);
      step();
    end

    // Fill the store, hit while full, overflow stall, flush
    for (int i = 0; i < 16; i++) send(1'b0, 16'h0100 + 16'(i), 12'h0, 32'h1000 + 32'(i), 1'b0, w);
    step();
    @(negedge clk);
    chk("fill_full", 64'(full_o), 1);
    chk("fill_cnt", 64'(cnt_o), 16);
    step();
    send(1'b1, 16'h0103, 12'h0, 32'hCAFE, 1'b0, w);
    wait_out(cyc);
    chk("fullhit_l", 64'(out_l_o), 64'h1003);
    chk("fullhit_r", 64'(out_r_o), 64'hCAFE);
    chk("fullhit_cnt", 64'(cnt_o), 15);
    chk("fullhit_notfull", 64'(full_o), 0);
    step();
    send(1'b0, 16'h01FF, 12'h0, 32'h1FF, 1'b0, w);
    send(1'b0, 16'h0200, 12'h0, 32'h200, 1'b0, w);
    drive(1'b1, 16'h0102, 12'h0, 32'hBEEF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ovf_in_rdy", 64'(in_rdy_o), 0);
    end
    chk("ovf_stall", 64'(stall_full_o), 1);
    chk("ovf_cnt", 64'(cnt_o), 16);
    step();
    in_vld_i = 1'b0;
    flush_i  = 1'b1;
    @(negedge clk);
    chk("flush_in_rdy", 64'(in_rdy_o), 0);
    step();
    flush_i = 1'b0;
    @(negedge clk);
    chk("flush_cnt", 64'(cnt_o), 0);
    chk("flush_empty", 64'(empty_o), 1);
    chk("flush_in_rdy_after", 64'(in_rdy_o), 1);
    chk("flush_stall_kept", 64'(stall_full_o), 1);
    step();
    send(1'b1, 16'h0102, 12'h0, 32'hBEEF, 1'b0, w);
    step();
    @(negedge clk);
    chk("postflush_nofire", 64'(out_vld_o), 0);
    chk("postflush_cnt", 64'(cnt_o), 1);
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;

    // Output backpressure: firing token held in S0, then drain in order
    out_rdy_i = 1'b0;
    send(1'b0, 16'h0300, 12'h1, 32'hA1, 1'b0, w);
    send(1'b1, 16'h0300, 12'h1, 32'hB1, 1'b0, w);
    send(1'b0, 16'h0301, 12'h1, 32'hA2, 1'b0, w);
    send(1'b1, 16'h0301, 12'h1, 32'hB2, 1'b0, w);
    chk("bp_accept_b2", 64'(w), 0);
    drive(1'b0, 16'h0302, 12'h1, 32'hA3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_rdy", 64'(in_rdy_o), 0);
      chk("bp_vld", 64'(out_vld_o), 1);
      chk("bp_l", 64'(out_l_o), 64'hA1);
      chk("bp_r", 64'(out_r_o), 64'hB1);
    end
    step();
    out_rdy_i = 1'b1;
    nsent = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_vld_o) begin
        cap_l.push_back(out_l_o);
        cap_r.push_back(out_r_o);
        cap_c.push_back(c);
      end
      acc = in_vld_i && in_rdy_o;
      step();
      if (acc) begin
        nsent++;
        if (nsent == 1) drive(1'b1, 16'h0302, 12'h1, 32'hB3, 1'b0);
        else in_vld_i = 1'b0;
      end
    end
    chk("bp_count", 64'(cap_l.size()), 3);
    if (cap_l.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("bp_order_l%0d", i), 64'(cap_l[i]), 64'(32'hA1 + 32'(i)));
        chk($sformatf("bp_order_r%0d", i), 64'(cap_r[i]), 64'(32'hB1 + 32'(i)));
      end
      chk("bp_back_to_back", 64'(cap_c[1]), 64'(cap_c[0] + 1));
    end

    // Asynchronous reset mid-stream
    out_rdy_i = 1'b0;
    send(1'b0, 16'h0400, 12'h2, 32'h41, 1'b0, w);
    send(1'b1, 16'h0400, 12'h2, 32'h42, 1'b0, w);
    for (int i = 0; i < 5; i++) send(1'b0, 16'h0500 + 16'(i), 12'h3, 32'h50 + 32'(i), 1'b0, w);
    step();
    step();
    @(negedge clk);
    chk("pre_rst_cnt", 64'(cnt_o), 5);
    chk("pre_rst_vld", 64'(out_vld_o), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_vld", 64'(out_vld_o), 0);
    chk("arst_l", 64'(out_l_o), 0);
    chk("arst_r", 64'(out_r_o), 0);
    chk("arst_cnt", 64'(cnt_o), 0);
    chk("arst_empty", 64'(empty_o), 1);
    chk("arst_in_rdy", 64'(in_rdy_o), 1);
    chk("arst_stall", 64'(stall_full_o), 0);
    @(posedge clk);
    #3 rst = 1'b1;
    out_rdy_i = 1'b1;
    send(1'b1, 16'h0500, 12'h3, 32'h77, 1'b0, w);
    fired = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_vld_o) fired++;
    end
    chk("arst_lone_nofire", 64'(fired), 0);
    chk("arst_lone_cnt", 64'(cnt_o), 1);
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      in_vld_i  = ($urandom_range(0, 3) != 0);
      in_lr_i   = 1'($urandom_range(0, 1));
      in_node_i = 16'($urandom_range(1, 2));
      in_gen_i  = 12'($urandom_range(0, 1));
      in_opr_i  = $urandom;
      in_uni_i  = ($urandom_range(0, 7) == 0);
      out_rdy_i = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_vld_i && in_rdy_o) model_accept();
      if (out_vld_o && out_rdy_i) model_out();
      step();
    end
    in_vld_i  = 1'b0;
    out_rdy_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_vld_o && out_rdy_i) model_out();
      step();
    end
    chk("rnd_drained", 64'(exp_q.size()), 0);
    chk("rnd_cnt", 64'(cnt_o), 64'(pend.num()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_match_stage.md
# fc_match_stage

Parametrised firing-control matching stage for the CUES dataflow pipeline. It sits between TC1 and FC1 and pairs operand tokens that share a {node, generation} key. It holds waiting tokens in a DEPTH-entry associative store and emits a fired token (left and right operands) once the partner arrives; unary tokens bypass the store. Compared with the fixed-width FC0/MM pair, it adds valid/ready backpressure, a configurable key, data width and depth, operand ordering by L/R flag, flush, and occupancy reporting.

## Interface
- NODE_W, 16, node-number width
- GEN_W, 12, generation width; key = {node, gen}, KEY_W = NODE_W+GEN_W
- DATA_W, 32, operand width
- DEPTH, 16, matching-store entries; power of two, ≥2
- CW, $clog2(DEPTH+1), occupancy-count width (derived, not overridable)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_vld_i  in  1  input token valid
- in_rdy_o  out  1  stage can accept the token
- in_lr_i  in  1  operand side: 0 = left, 1 = right
- in_node_i  in  NODE_W  destination node
- in_gen_i  in  GEN_W  generation
- in_opr_i  in  DATA_W  operand data
- in_uni_i  in  1  unary token; never stored
- flush_i  in  1  clear the store and stage S0
- out_vld_o  out  1  fired token valid
- out_rdy_i  in  1  FC1 accepts the fired token
- out_node_o / out_gen_o  out  NODE_W / GEN_W  fired key
- out_l_o / out_r_o  out  DATA_W  left and right operands
- out_uni_o  out  1  fired token is unary
- cnt_o  out  CW  number of valid store entries
- full_o / empty_o  out  1  cnt_o==DEPTH / cnt_o==0
- stall_full_o  out  1  sticky: a store was blocked because the store was full

## Operation
- S0 register holds {lr, node, gen, opr, uni, s0_vld}. It loads on in_vld_i & in_rdy_o.
- Lookup is combinational on S0 against all entries. Hit = entry valid and its key equals the S0 key. The lowest-index hit wins. The L/R flag is not compared.
- fire = s0_vld & (uni | hit).
- s0_adv = fire ? (~out_vld_o | out_rdy_i) : (s0_vld & ~full_o).
- in_rdy_o = ~s0_vld | s0_adv. This is a combinational path from out_rdy_i and is permitted.
- On s0_adv:
  - Hit: the matched entry is invalidated. The S1 output register loads the fired token.
    - If S0 lr=0: out_l_o = S0 opr, out_r_o = entry data.
    - If S0 lr=1: the two are swapped.
  - Unary: S1 loads out_l_o = opr, out_r_o = 0, out_uni_o = 1. The store is untouched.
  - Miss (not unary): the lowest-index free entry is written with {key, opr}. No output is produced.
- Each stored entry holds {key, data, valid}.
- cnt_o changes by at most ±1 per cycle: +1 on store, −1 on hit. Store and hit never occur in the same cycle.
- S1 holds its contents while out_vld_o & ~out_rdy_i. It clears out_vld_o on out_rdy_i when no new fire occurs.
- stall_full_o sets in any cycle where s0_vld & ~uni & ~hit & full_o. It clears only on reset.
- flush_i has priority over everything in that cycle:
  - All valid bits and s0_vld clear at the next edge; cnt_o becomes 0.
  - in_rdy_o = 0 during the flush cycle.
  - S1 and stall_full_o are unaffected.

## Timing
- Reset (rst=0, asynchronous) forces:
  - in_rdy_o=1 (s0_vld=0), out_vld_o=0, all out_* data=0, out_uni_o=0.
  - cnt_o=0, full_o=0, empty_o=1, stall_full_o=0, all entry valid bits=0.
- Reset asserted mid-operation discards all stored and in-flight tokens immediately.
- Latency: a token accepted at edge k is in S0 after edge k. If it fires, out_vld_o=1 after edge k+1.
- Throughput: one token per cycle when there is no backpressure.
- Back-to-back tokens with the same key (A at edge k, B at edge k+1) must match. A's entry write and B's S0 load happen at the same edge, so no forwarding is needed.
- Full store with a non-matching S0 token: S0 holds and in_rdy_o=0 until flush or reset. Hits and unary tokens still advance while the store is full.
- A hit while the store is full frees an entry, so full_o deasserts after that edge.
- Output stall with a firing S0 token: S0 holds and in_rdy_o=0. A non-firing S0 token still advances by storing while out_vld_o=1.

## Test plan
- Reset, then left token key 0x0005/0x001, data 0xAAAA0000 → cnt_o=1, out_vld_o stays 0. Then a right token with the same key, data 0x0000BBBB → two edges later out_vld_o=1, out_l_o=0xAAAA0000, out_r_o=0x0000BBBB, cnt_o=0, empty_o=1.
- Right token first (data 0x11), then left token with the same key (data 0x22) on the very next cycle → out_l_o=0x22, out_r_o=0x11, no bubble between the two accepts.
- Unary token data 0x1234 → out_vld_o after 2 edges, out_l_o=0x1234, out_r_o=0, out_uni_o=1, cnt_o unchanged.
- 16 distinct keys (DEPTH=16) → full_o=1. A 17th distinct key → in_rdy_o=0, stall_full_o=1. Then a partner of key #3 is held behind it. Assert flush_i → cnt_o=0, in_rdy_o=1 next cycle, stall_full_o remains 1.
- Hold out_rdy_i=0 with 3 matching pairs queued → out_* stay stable, in_rdy_o=0 while the S0 token fires. Release out_rdy_i → pairs emerge one per cycle in arrival order.
- Assert rst for one cycle mid-stream with cnt_o=5 and out_vld_o=1 → all outputs return to reset values asynchronously; a subsequent lone token does not fire.
